demod_ctrl: RTL and testbench

//   Sequencer for the FM demodulator datapath: paired real/imag input FIFOs -> demodulate core -> output FIFO.

---
 rtl/demod_ctrl_pkg.sv | 23 ++
 rtl/demod_ctrl_if.sv | 25 ++
 rtl/demod_ctrl_up_down_counter.sv | 35 +++
 rtl/demod_ctrl.sv | 127 ++++++++++++
 tb/tb_demod_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/demod_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | demod_ctrl_pkg : shared types and defaults for the demod sequencer    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package demod_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } demod_state_t;

  localparam int DEFAULT_OUT_FIFO_DEPTH = 1024;
  localparam int DEFAULT_CNT_WIDTH      = 32;

  // Counter width able to hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demod_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | demod_ctrl_if : FIFO / core handshake flags around the sequencer      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface demod_ctrl_if;
  logic real_empty;
  logic imag_empty;
  logic core_out_valid;
  logic out_rd_en;
  logic out_fifo_empty;
  logic in_rd_en;
  logic core_in_valid;

  modport master (
    input  real_empty, imag_empty, core_out_valid, out_rd_en, out_fifo_empty,
    output in_rd_en, core_in_valid
  );

  modport slave (
    output real_empty, imag_empty, core_out_valid, out_rd_en, out_fifo_empty,
    input  in_rd_en, core_in_valid
  );
endinterface
`default_nettype wire

// File: rtl/demod_ctrl_up_down_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | demod_ctrl_up_down_counter : saturating up/down counter, underflow    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module demod_ctrl_up_down_counter #(
  parameter int WIDTH = 11,
  parameter int MAX   = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             underflow
);
  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX);

  logic [WIDTH-1:0] r_count;

  // Simultaneous inc/dec cancel; a lone dec at zero holds and flags.
  assign underflow = dec && !inc && (r_count == '0);
  assign count     = r_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (inc && !dec && (r_count != C_MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end else if (dec && !inc && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end
endmodule
`default_nettype wire

// File: rtl/demod_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | demod_ctrl : credit-based sequencer for the FM demodulator datapath   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module demod_ctrl
  import demod_ctrl_pkg::*;
#(
  parameter int OUT_FIFO_DEPTH = DEFAULT_OUT_FIFO_DEPTH,
  parameter int CNT_WIDTH      = DEFAULT_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [CNT_WIDTH-1:0] block_len,
  demod_ctrl_if.master         dp,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] sample_count,
  output logic                 err_desync,
  output logic                 err_underflow
);
  localparam int C_OCC_W = occ_width(OUT_FIFO_DEPTH);

  demod_state_t         r_state;
  logic [CNT_WIDTH-1:0] r_len_q;
  logic [CNT_WIDTH-1:0] r_sample_count;
  logic                 r_core_in_valid;
  logic                 r_done;
  logic                 r_err_desync;
  logic                 r_err_underflow;

  logic [C_OCC_W-1:0]   w_inflight;
  logic [C_OCC_W-1:0]   w_occ;
  logic [C_OCC_W:0]     w_credit_sum;
  logic                 w_credit_ok;
  logic                 w_len_reached;
  logic                 w_in_rd_en;
  logic                 w_out_read;
  logic                 w_inflight_underflow;
  logic                 w_occ_unused_underflow;
  logic                 w_drain_empty;
  logic                 w_desync;
  logic [CNT_WIDTH-1:0] w_count_next;

  // Credit covers both what sits in the output FIFO and what the core still owes it.
  assign w_credit_sum  = {1'b0, w_occ} + {1'b0, w_inflight};
  assign w_credit_ok   = w_credit_sum < (C_OCC_W + 1)'(OUT_FIFO_DEPTH);
  assign w_len_reached = (r_len_q != '0) && (r_sample_count == r_len_q);
  assign w_in_rd_en    = (r_state == S_RUN) && !dp.real_empty && !dp.imag_empty
                         && w_credit_ok && !w_len_reached;
  assign w_count_next  = r_sample_count + CNT_WIDTH'(w_in_rd_en);
  assign w_out_read    = dp.out_rd_en && !dp.out_fifo_empty;
  assign w_desync      = dp.real_empty != dp.imag_empty;
  // Look one edge ahead so IDLE and done land the cycle after the last core result.
  assign w_drain_empty = (w_inflight == '0)
                         || ((w_inflight == C_OCC_W'(1)) && dp.core_out_valid);

  demod_ctrl_up_down_counter #(.WIDTH(C_OCC_W), .MAX(OUT_FIFO_DEPTH)) u_inflight (
    .clk       (clk),
    .reset     (reset),
    .inc       (w_in_rd_en),
    .dec       (dp.core_out_valid),
    .count     (w_inflight),
    .underflow (w_inflight_underflow)
  );

  demod_ctrl_up_down_counter #(.WIDTH(C_OCC_W), .MAX(OUT_FIFO_DEPTH)) u_occ (
    .clk       (clk),
    .reset     (reset),
    .inc       (dp.core_out_valid),
    .dec       (w_out_read),
    .count     (w_occ),
    .underflow (w_occ_unused_underflow)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_len_q         <= '0;
      r_sample_count  <= '0;
      r_core_in_valid <= 1'b0;
      r_done          <= 1'b0;
      r_err_desync    <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_core_in_valid <= w_in_rd_en;
      r_done          <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state         <= S_RUN;
            r_len_q         <= block_len;
            r_sample_count  <= '0;
            r_err_desync    <= 1'b0;
            r_err_underflow <= 1'b0;
          end
        end
        S_RUN: begin
          r_sample_count <= w_count_next;
          if (stop || ((r_len_q != '0) && (w_count_next == r_len_q))) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_drain_empty) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_desync)             r_err_desync    <= 1'b1;
      if (w_inflight_underflow) r_err_underflow <= 1'b1;
    end
  end

  assign dp.in_rd_en      = w_in_rd_en;
  assign dp.core_in_valid = r_core_in_valid;
  assign busy             = (r_state != S_IDLE);
  assign done             = r_done;
  assign sample_count     = r_sample_count;
  assign err_desync       = r_err_desync;
  assign err_underflow    = r_err_underflow;
endmodule
`default_nettype wire

// File: tb/tb_demod_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_demod_ctrl : directed + randomized bench with a behavioural model  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_demod_ctrl;
  localparam int DEPTH = 8;
  localparam int CW    = 32;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] block_len = '0;
  logic          busy, done, err_desync, err_underflow;
  logic [CW-1:0] sample_count;

  demod_ctrl_if dp ();

  demod_ctrl #(.OUT_FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .stop          (stop),
    .block_len     (block_len),
    .dp            (dp),
    .busy          (busy),
    .done          (done),
    .sample_count  (sample_count),
    .err_desync    (err_desync),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the sequencer, in plain integers.
  int            m_state = M_IDLE;
  logic [CW-1:0] m_len = '0;
  logic [CW-1:0] m_cnt = '0;
  int            m_inflight = 0;
  int            m_occ = 0;
  bit            m_done = 0, m_civ = 0, m_desync = 0, m_underflow = 0;

  // Environment: 3-cycle core and an output FIFO occupancy.
  logic [2:0] core_q = '0;
  int         fifo_occ = 0;
  int         consumer_mode = 1;

  // Directed bookkeeping.
  int cyc = 0, rd_count = 0, first_rd = -1, last_rd = -1, last_cov = -1, done_cyc = -1;
  bit saw_done = 0, last_rd_val = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_issue();
    return (m_state == M_RUN) && !dp.real_empty && !dp.imag_empty
           && ((m_occ + m_inflight) < DEPTH)
           && !((m_len != 0) && (m_cnt == m_len));
  endfunction

  task automatic drive_consumer();
    case (consumer_mode)
      0:       dp.out_rd_en = 1'b0;
      1:       dp.out_rd_en = 1'b1;
      default: dp.out_rd_en = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clear_stats();
    rd_count = 0; first_rd = -1; last_rd = -1; last_cov = -1; done_cyc = -1; saw_done = 0;
  endtask

  // One clock cycle: inputs already driven; check, advance model, drive next cycle.
  task automatic tick();
    bit e_rd, cov, rdo, uf;
    cyc++;
    @(negedge clk);
    e_rd = exp_issue();
    check("in_rd_en",      dp.in_rd_en,      e_rd);
    check("core_in_valid", dp.core_in_valid, m_civ);
    check("busy",          busy,             m_state != M_IDLE);
    check("done",          done,             m_done);
    check("sample_count",  sample_count,     m_cnt);
    check("err_desync",    err_desync,       m_desync);
    check("err_underflow", err_underflow,    m_underflow);

    cov = dp.core_out_valid;
    rdo = dp.out_rd_en && !dp.out_fifo_empty;
    last_rd_val = dp.in_rd_en;
    if (dp.in_rd_en) begin
      rd_count++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (cov) last_cov = cyc;
    if (done) begin saw_done = 1; done_cyc = cyc; end

    uf = 0;
    m_done = 0;
    m_civ  = e_rd;
    if (e_rd && !cov) m_inflight++;
    else if (cov && !e_rd) begin
      if (m_inflight == 0) uf = 1; else m_inflight--;
    end
    if (cov && !rdo && m_occ < DEPTH) m_occ++;
    else if (rdo && !cov && m_occ > 0) m_occ--;
    case (m_state)
      M_IDLE: if (start) begin
        m_state = M_RUN; m_len = block_len; m_cnt = '0; m_desync = 0; m_underflow = 0;
      end
      M_RUN: begin
        if (e_rd) m_cnt = m_cnt + 1;
        if (stop || ((m_len != 0) && (m_cnt == m_len))) m_state = M_DRAIN;
      end
      default: if (m_inflight == 0) begin m_state = M_IDLE; m_done = 1; end
    endcase
    if (dp.real_empty != dp.imag_empty) m_desync = 1;
    if (uf) m_underflow = 1;

    core_q = {core_q[1:0], dp.in_rd_en};
    fifo_occ = fifo_occ + int'(cov) - int'(dp.out_rd_en && fifo_occ > 0);

    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    dp.core_out_valid = core_q[2];
    dp.out_fifo_empty = (fifo_occ == 0);
    drive_consumer();
  endtask

  task automatic run_until_done(input int budget, input string tag);
    for (int i = 0; i < budget && !saw_done; i++) tick();
    check(tag, saw_done, 1'b1);
  endtask

  task automatic mid_run_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_in_rd_en",     dp.in_rd_en,      1'b0);
    check("rst_core_in_valid", dp.core_in_valid, 1'b0);
    check("rst_busy",         busy,             1'b0);
    check("rst_sample_count", sample_count,     '0);
    m_state = M_IDLE; m_len = '0; m_cnt = '0; m_inflight = 0; m_occ = 0;
    m_done = 0; m_civ = 0; m_desync = 0; m_underflow = 0;
    core_q = '0; fifo_occ = 0;
    dp.core_out_valid = 1'b0;
    dp.out_fifo_empty = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", done, 1'b0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit stopped;
    bit e;
    dp.real_empty = 1'b0; dp.imag_empty = 1'b0; dp.core_out_valid = 1'b0;
    dp.out_rd_en = 1'b1;  dp.out_fifo_empty = 1'b1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_rd_en", dp.in_rd_en, 1'b0);
    check("reset_busy",     busy,        1'b0);
    check("reset_done",     done,        1'b0);
    check("reset_count",    sample_count, '0);
    check("reset_errs",     {err_desync, err_underflow}, 2'b00);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) tick();

    // Block of 8 with an always-ready consumer.
    clear_stats();
    block_len = 8; start = 1'b1;
    tick();
    begin
      int s;
      s = cyc;
      run_until_done(60, "t1_done_seen");
      check("t1_issue_count", rd_count, 8);
      check("t1_first_issue", first_rd, s + 1);
      check("t1_last_issue",  last_rd,  s + 8);
      check("t1_done_after_last_core", done_cyc, last_cov + 1);
      check("t1_sample_count", sample_count, 8);
    end
    repeat (4) tick();

    // Credit limit: consumer stalled.
    consumer_mode = 0; drive_consumer();
    clear_stats();
    block_len = 10; start = 1'b1;
    repeat (30) tick();
    check("t2_issues_at_credit", rd_count, DEPTH);
    check("t2_rd_idle_when_full", last_rd_val, 1'b0);
    consumer_mode = 1; drive_consumer();
    clear_stats();
    tick(); tick();
    consumer_mode = 0; drive_consumer();
    repeat (15) tick();
    check("t2_issues_after_two_reads", rd_count, 2);
    check("t2_done_seen", saw_done, 1'b1);
    consumer_mode = 1; drive_consumer();
    repeat (14) tick();

    // Continuous mode, stop on the cycle that issues sample 6.
    consumer_mode = 2;
    clear_stats();
    block_len = 0; start = 1'b1;
    tick();
    stopped = 0;
    for (int i = 0; i < 300 && !(stopped && saw_done); i++) begin
      e = ($urandom_range(0, 3) == 0);
      dp.real_empty = e; dp.imag_empty = e;
      if (!stopped && m_state == M_RUN && m_cnt == 5 && exp_issue()) begin
        stop = 1'b1; stopped = 1;
      end
      tick();
    end
    dp.real_empty = 1'b0; dp.imag_empty = 1'b0;
    check("t3_stop_applied",  stopped,  1'b1);
    check("t3_done_seen",     saw_done, 1'b1);
    check("t3_issue_count",   rd_count, 6);
    check("t3_sample_count",  sample_count, 6);
    check("t3_busy_cleared",  busy,     1'b0);

    // Randomized blocks with stray start/stop pulses.
    for (int b = 0; b < 4; b++) begin
      clear_stats();
      block_len = CW'($urandom_range(1, 20)); start = 1'b1;
      tick();
      for (int i = 0; i < 400 && !saw_done; i++) begin
        e = ($urandom_range(0, 2) == 0);
        dp.real_empty = e; dp.imag_empty = e;
        if (m_state != M_IDLE && $urandom_range(0, 9) == 0) start = 1'b1;
        if ($urandom_range(0, 39) == 0) stop = 1'b1;
        tick();
      end
      check("rand_done_seen", saw_done, 1'b1);
    end
    dp.real_empty = 1'b0; dp.imag_empty = 1'b0;
    consumer_mode = 1; drive_consumer();
    repeat (12) tick();

    // Desync is sticky until the next start.
    dp.real_empty = 1'b1; dp.imag_empty = 1'b0;
    tick();
    dp.real_empty = 1'b0;
    repeat (3) tick();
    check("t4_desync_sticky", err_desync, 1'b1);
    clear_stats();
    block_len = 2; start = 1'b1;
    tick();
    check("t4_desync_cleared_by_start", err_desync, 1'b0);
    run_until_done(40, "t4_done_seen");
    repeat (6) tick();

    // Core result with nothing in flight.
    dp.core_out_valid = 1'b1;
    tick();
    tick();
    check("t4_underflow_set", err_underflow, 1'b1);
    repeat (4) tick();

    // Reset in the middle of a continuous run with three samples in flight.
    clear_stats();
    block_len = 0; start = 1'b1;
    tick();
    repeat (3) tick();
    check("t5_three_issued", rd_count, 3);
    mid_run_reset();
    clear_stats();
    repeat (2) tick();
    block_len = 8; start = 1'b1;
    tick();
    run_until_done(60, "t5_done_after_reset");
    check("t5_issue_count", rd_count, 8);
    check("t5_sample_count", sample_count, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
